iq_demod_stage: RTL and testbench

IQ_DEMOD_STAGE -- requirements
Module: iq_demod_stage

---
 rtl/iq_demod_stage.sv | 266 ++++++++++++++++++++++++++
 tb/tb_iq_demod_stage.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_demod_stage.sv
`default_nettype none
// ============================================================================
// Module      : iq_demod_stage
// Description : FM discriminator / bypass stage for packed I/Q samples.
//               Input FIFO (I and Q stored together) -> 3-stage pipeline
//               (pop/register, products, combine/shift/saturate) -> FWFT
//               output FIFO. Has a wrapping output-sample counter and a
//               sticky input-overflow flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            : sole clock, rising edge
//   reset          : asynchronous, active-low reset
//   iq_in          : packed sample, [2W-1:W] = I, [W-1:0] = Q
//   iq_wr_en       : push iq_in into the input FIFO
//   iq_full        : input FIFO full
//   mode           : 0 = FM discriminator, 1 = bypass (output I)
//   data_out       : head of output FIFO (0 while empty)
//   data_out_rd_en : pop the output FIFO
//   data_out_empty : output FIFO empty
//   sample_count   : number of samples written to the output FIFO
//   overflow       : sticky, a write hit a full input FIFO
//   clear_status   : synchronous clear of sample_count and overflow
// ============================================================================
module iq_demod_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int GAIN_SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2*DATA_WIDTH-1:0] iq_in,
    input  logic                    iq_wr_en,
    output logic                    iq_full,
    input  logic                    mode,
    output logic [DATA_WIDTH-1:0]   data_out,
    input  logic                    data_out_rd_en,
    output logic                    data_out_empty,
    output logic [31:0]             sample_count,
    output logic                    overflow,
    input  logic                    clear_status
);

    localparam int c_w  = DATA_WIDTH;
    localparam int c_pw = 2 * DATA_WIDTH;
    localparam int c_aw = $clog2(FIFO_DEPTH);

    localparam logic [c_aw:0] c_ptr_one = {{c_aw{1'b0}}, 1'b1};
    // Saturation bounds expressed at full discriminator precision.
    localparam logic signed [c_pw:0] c_sat_max = {{(c_w+2){1'b0}}, {(c_w-1){1'b1}}};
    localparam logic signed [c_pw:0] c_sat_min = {{(c_w+2){1'b1}}, {(c_w-1){1'b0}}};

    // ------------------------------------------------------------------
    // Input FIFO (I and Q in one word so they cannot desynchronise)
    // ------------------------------------------------------------------
    logic [c_pw-1:0] in_mem_q [FIFO_DEPTH];
    logic [c_aw:0]   in_wr_ptr_q, in_wr_ptr_d;
    logic [c_aw:0]   in_rd_ptr_q, in_rd_ptr_d;
    logic            w_in_empty;
    logic            w_in_wr;
    logic [c_pw-1:0] w_in_head;

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [c_w-1:0]  out_mem_q [FIFO_DEPTH];
    logic [c_aw:0]   out_wr_ptr_q, out_wr_ptr_d;
    logic [c_aw:0]   out_rd_ptr_q, out_rd_ptr_d;
    logic            w_out_full;
    logic            w_out_rd;

    // ------------------------------------------------------------------
    // Pipeline state ("re" = I, "im" = Q)
    // ------------------------------------------------------------------
    logic                    w_advance, w_pop, w_out_wr;

    logic                    s1_valid_q, s1_valid_d;
    logic                    s1_mode_q,  s1_mode_d;
    logic signed [c_w-1:0]   s1_re_q,    s1_re_d;
    logic signed [c_w-1:0]   s1_im_q,    s1_im_d;
    logic signed [c_w-1:0]   s1_pre_q,   s1_pre_d;
    logic signed [c_w-1:0]   s1_pim_q,   s1_pim_d;
    logic signed [c_w-1:0]   prev_re_q,  prev_re_d;
    logic signed [c_w-1:0]   prev_im_q,  prev_im_d;

    logic                    s2_valid_q, s2_valid_d;
    logic                    s2_mode_q,  s2_mode_d;
    logic signed [c_w-1:0]   s2_re_q,    s2_re_d;
    logic signed [c_pw-1:0]  s2_p1_q,    s2_p1_d;
    logic signed [c_pw-1:0]  s2_p2_q,    s2_p2_d;

    logic                    s3_valid_q, s3_valid_d;
    logic [c_w-1:0]          s3_data_q,  s3_data_d;

    logic [31:0]             sample_count_q, sample_count_d;
    logic                    overflow_q,     overflow_d;

    logic signed [c_pw-1:0]  w_a1, w_b1, w_a2, w_b2;
    logic signed [c_pw:0]    w_p1x, w_p2x, w_diff, w_shift;
    logic [c_w-1:0]          w_sat;

    // ---------------- input FIFO ----------------
    assign iq_full    = (in_wr_ptr_q[c_aw] != in_rd_ptr_q[c_aw]) &&
                        (in_wr_ptr_q[c_aw-1:0] == in_rd_ptr_q[c_aw-1:0]);
    assign w_in_empty = (in_wr_ptr_q == in_rd_ptr_q);
    assign w_in_wr    = iq_wr_en && !iq_full;   // full-FIFO write is dropped
    assign w_in_head  = in_mem_q[in_rd_ptr_q[c_aw-1:0]];

    always_comb begin
        in_wr_ptr_d = in_wr_ptr_q;
        in_rd_ptr_d = in_rd_ptr_q;
        if (w_in_wr) in_wr_ptr_d = in_wr_ptr_q + c_ptr_one;
        if (w_pop)   in_rd_ptr_d = in_rd_ptr_q + c_ptr_one;
    end

    always_ff @(posedge clk) begin
        if (w_in_wr) in_mem_q[in_wr_ptr_q[c_aw-1:0]] <= iq_in;
    end

    // ---------------- output FIFO ----------------
    assign w_out_full     = (out_wr_ptr_q[c_aw] != out_rd_ptr_q[c_aw]) &&
                            (out_wr_ptr_q[c_aw-1:0] == out_rd_ptr_q[c_aw-1:0]);
    assign data_out_empty = (out_wr_ptr_q == out_rd_ptr_q);
    assign w_out_rd       = data_out_rd_en && !data_out_empty;
    // Head is forced to zero while empty so reset leaves no stale sample.
    assign data_out       = data_out_empty ? '0 : out_mem_q[out_rd_ptr_q[c_aw-1:0]];

    always_comb begin
        out_wr_ptr_d = out_wr_ptr_q;
        out_rd_ptr_d = out_rd_ptr_q;
        if (w_out_wr) out_wr_ptr_d = out_wr_ptr_q + c_ptr_one;
        if (w_out_rd) out_rd_ptr_d = out_rd_ptr_q + c_ptr_one;
    end

    always_ff @(posedge clk) begin
        if (w_out_wr) out_mem_q[out_wr_ptr_q[c_aw-1:0]] <= s3_data_q;
    end

    // ---------------- pipeline control ----------------
    // Whole pipeline freezes only when the S3 result has nowhere to go.
    assign w_advance = !(s3_valid_q && w_out_full);
    assign w_pop     = w_advance && !w_in_empty;
    assign w_out_wr  = s3_valid_q && w_advance;

    // Sign-extend operands to product width so the multiply is exact.
    assign w_a1 = {{c_w{s1_im_q[c_w-1]}},  s1_im_q};
    assign w_b1 = {{c_w{s1_pre_q[c_w-1]}}, s1_pre_q};
    assign w_a2 = {{c_w{s1_re_q[c_w-1]}},  s1_re_q};
    assign w_b2 = {{c_w{s1_pim_q[c_w-1]}}, s1_pim_q};

    assign w_p1x   = {s2_p1_q[c_pw-1], s2_p1_q};
    assign w_p2x   = {s2_p2_q[c_pw-1], s2_p2_q};
    assign w_diff  = w_p1x - w_p2x;
    assign w_shift = w_diff >>> GAIN_SHIFT;

    always_comb begin
        w_sat = w_shift[c_w-1:0];
        if (w_shift > c_sat_max)      w_sat = c_sat_max[c_w-1:0];
        else if (w_shift < c_sat_min) w_sat = c_sat_min[c_w-1:0];
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_re_d    = s1_re_q;
        s1_im_d    = s1_im_q;
        s1_pre_d   = s1_pre_q;
        s1_pim_d   = s1_pim_q;
        prev_re_d  = prev_re_q;
        prev_im_d  = prev_im_q;
        s2_valid_d = s2_valid_q;
        s2_mode_d  = s2_mode_q;
        s2_re_d    = s2_re_q;
        s2_p1_d    = s2_p1_q;
        s2_p2_d    = s2_p2_q;
        s3_valid_d = s3_valid_q;
        s3_data_d  = s3_data_q;
        if (w_advance) begin
            s1_valid_d = w_pop;
            if (w_pop) begin
                s1_re_d   = w_in_head[c_pw-1:c_w];
                s1_im_d   = w_in_head[c_w-1:0];
                s1_pre_d  = prev_re_q;
                s1_pim_d  = prev_im_q;
                s1_mode_d = mode;
                // History follows every popped sample, bypass included.
                prev_re_d = w_in_head[c_pw-1:c_w];
                prev_im_d = w_in_head[c_w-1:0];
            end
            s2_valid_d = s1_valid_q;
            s2_mode_d  = s1_mode_q;
            s2_re_d    = s1_re_q;
            s2_p1_d    = w_a1 * w_b1;   // Q[n] * I[n-1]
            s2_p2_d    = w_a2 * w_b2;   // I[n] * Q[n-1]
            s3_valid_d = s2_valid_q;
            s3_data_d  = s2_mode_q ? s2_re_q : w_sat;
        end
    end

    // ---------------- status ----------------
    always_comb begin
        sample_count_d = sample_count_q;
        overflow_d     = overflow_q;
        if (clear_status) begin
            sample_count_d = '0;
            overflow_d     = 1'b0;
        end else begin
            if (w_out_wr)            sample_count_d = sample_count_q + 32'd1;
            if (iq_wr_en && iq_full) overflow_d     = 1'b1;
        end
    end

    assign sample_count = sample_count_q;
    assign overflow     = overflow_q;

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_wr_ptr_q    <= '0;
            in_rd_ptr_q    <= '0;
            out_wr_ptr_q   <= '0;
            out_rd_ptr_q   <= '0;
            s1_valid_q     <= 1'b0;
            s1_mode_q      <= 1'b0;
            s1_re_q        <= '0;
            s1_im_q        <= '0;
            s1_pre_q       <= '0;
            s1_pim_q       <= '0;
            prev_re_q      <= '0;
            prev_im_q      <= '0;
            s2_valid_q     <= 1'b0;
            s2_mode_q      <= 1'b0;
            s2_re_q        <= '0;
            s2_p1_q        <= '0;
            s2_p2_q        <= '0;
            s3_valid_q     <= 1'b0;
            s3_data_q      <= '0;
            sample_count_q <= '0;
            overflow_q     <= 1'b0;
        end else begin
            in_wr_ptr_q    <= in_wr_ptr_d;
            in_rd_ptr_q    <= in_rd_ptr_d;
            out_wr_ptr_q   <= out_wr_ptr_d;
            out_rd_ptr_q   <= out_rd_ptr_d;
            s1_valid_q     <= s1_valid_d;
            s1_mode_q      <= s1_mode_d;
            s1_re_q        <= s1_re_d;
            s1_im_q        <= s1_im_d;
            s1_pre_q       <= s1_pre_d;
            s1_pim_q       <= s1_pim_d;
            prev_re_q      <= prev_re_d;
            prev_im_q      <= prev_im_d;
            s2_valid_q     <= s2_valid_d;
            s2_mode_q      <= s2_mode_d;
            s2_re_q        <= s2_re_d;
            s2_p1_q        <= s2_p1_d;
            s2_p2_q        <= s2_p2_d;
            s3_valid_q     <= s3_valid_d;
            s3_data_q      <= s3_data_d;
            sample_count_q <= sample_count_d;
            overflow_q     <= overflow_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iq_demod_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_iq_demod_stage
// Description : Self-checking bench for iq_demod_stage. Two instances share
//               all inputs (GAIN_SHIFT 0 and 15); a queue-based model of the
//               accepted sample stream predicts every popped output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iq_demod_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] iq_in = '0;
    logic        iq_wr_en = 1'b0;
    logic        mode = 1'b0;
    logic        data_out_rd_en = 1'b0;
    logic        clear_status = 1'b0;

    logic        iq_full0, iq_full15;
    logic [15:0] data_out0, data_out15;
    logic        data_out_empty0, data_out_empty15;
    logic [31:0] sample_count0, sample_count15;
    logic        overflow0, overflow15;

    int n_chk = 0;
    int n_fail = 0;
    int rd_pct = 0;
    int acc_cnt = 0;
    int prev_i = 0;
    int prev_q = 0;
    bit ovf_m = 1'b0;
    int exp0[$];
    int exp15[$];
    int got0[$];
    int got15[$];

    iq_demod_stage #(.DATA_WIDTH(16), .FIFO_DEPTH(16), .GAIN_SHIFT(0)) dut0 (
        .clk(clk), .reset(reset), .iq_in(iq_in), .iq_wr_en(iq_wr_en),
        .iq_full(iq_full0), .mode(mode), .data_out(data_out0),
        .data_out_rd_en(data_out_rd_en), .data_out_empty(data_out_empty0),
        .sample_count(sample_count0), .overflow(overflow0),
        .clear_status(clear_status)
    );

    iq_demod_stage #(.DATA_WIDTH(16), .FIFO_DEPTH(16), .GAIN_SHIFT(15)) dut15 (
        .clk(clk), .reset(reset), .iq_in(iq_in), .iq_wr_en(iq_wr_en),
        .iq_full(iq_full15), .mode(mode), .data_out(data_out15),
        .data_out_rd_en(data_out_rd_en), .data_out_empty(data_out_empty15),
        .sample_count(sample_count15), .overflow(overflow15),
        .clear_status(clear_status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Discriminator straight from the arithmetic definition.
    function automatic int model(input int i, input int q, input int pi, input int pq,
                                 input bit md, input int sh);
        longint d;
        if (md) return i;
        d = longint'(q) * longint'(pi) - longint'(i) * longint'(pq);
        d = d >>> sh;
        if (d > 32767)  return 32767;
        if (d < -32768) return -32768;
        return int'(d);
    endfunction

    function automatic int rnd_s();
        case ($urandom_range(7))
            0:       return -32768;
            1:       return 32767;
            2:       return 0;
            default: return int'($urandom_range(65535)) - 32768;
        endcase
    endfunction

    // Random reader: pops with probability rd_pct percent each cycle.
    always @(posedge clk) begin
        #1;
        data_out_rd_en = (int'($urandom_range(99)) < rd_pct);
    end

    // Compare process: sees stable values mid-cycle, i.e. exactly what the
    // next rising edge will act on.
    always @(negedge clk) begin
        int si, sq;
        if (!reset) begin
            exp0.delete();
            exp15.delete();
            prev_i  = 0;
            prev_q  = 0;
            ovf_m   = 1'b0;
            acc_cnt = 0;
        end else begin
            chk("overflow_s0", overflow0, ovf_m);
            chk("overflow_s15", overflow15, ovf_m);
            if (exp0.size() == 0) chk("empty_when_idle", data_out_empty0, 1);
            if (data_out_rd_en && !data_out_empty0) begin
                if (exp0.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    chk("data_out_s0", $signed(data_out0), exp0.pop_front());
                    chk("data_out_s15", $signed(data_out15), exp15.pop_front());
                    got0.push_back(int'($signed(data_out0)));
                    got15.push_back(int'($signed(data_out15)));
                end
            end
            if (iq_wr_en && !iq_full0) begin
                si = int'($signed(iq_in[31:16]));
                sq = int'($signed(iq_in[15:0]));
                exp0.push_back(model(si, sq, prev_i, prev_q, mode, 0));
                exp15.push_back(model(si, sq, prev_i, prev_q, mode, 15));
                prev_i = si;
                prev_q = sq;
                acc_cnt++;
            end
            if (clear_status) begin
                ovf_m   = 1'b0;
                acc_cnt = 0;
            end else if (iq_wr_en && iq_full0) begin
                ovf_m = 1'b1;
            end
        end
    end

    task automatic drive(input bit en, input int i, input int q);
        @(posedge clk);
        #1;
        iq_in    = {i[15:0], q[15:0]};
        iq_wr_en = en;
    endtask

    task automatic drain();
        int k;
        rd_pct = 100;
        for (k = 0; k < 3000; k++) begin
            @(posedge clk);
            if (exp0.size() == 0 && data_out_empty0) break;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_complete", exp0.size(), 0);
        rd_pct = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_pulse();
        @(posedge clk);
        #1 clear_status = 1'b1;
        @(posedge clk);
        #1 clear_status = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        #12;
        chk("rst_iq_full", iq_full0, 0);
        chk("rst_empty", data_out_empty0, 1);
        chk("rst_data_out", data_out0, 0);
        chk("rst_count", sample_count0, 0);
        chk("rst_overflow", overflow0, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // ---------------- basic discriminator + latency ----------------
        got0.delete(); got15.delete();
        drive(1, 100, 0);          // lands on edge N
        drive(1, 0, 100);
        drive(1, -100, 0);
        drive(0, 0, 0);            // now just after edge N+2
        @(posedge clk); #1;        // after N+3
        chk("latency_before", data_out_empty0, 1);
        @(posedge clk); #1;        // after N+4
        chk("latency_at", data_out_empty0, 0);
        drain();
        chk("basic_n", got0.size(), 3);
        if (got0.size() == 3) begin
            chk("basic_0", got0[0], 0);
            chk("basic_1", got0[1], 10000);
            chk("basic_2", got0[2], 10000);
            chk("basic_s15_1", got15[1], 0);
        end
        chk("count_basic", sample_count0, 3);

        // ---------------- saturation ----------------
        got0.delete(); got15.delete();
        drive(1, 32767, 0);
        drive(1, 0, 32767);
        drive(0, 0, 0);
        drain();
        chk("sat_n", got0.size(), 2);
        if (got0.size() == 2) begin
            chk("sat_0", got0[0], 0);
            chk("sat_1", got0[1], 32767);
            chk("sat_s15_0", got15[0], 0);
            chk("sat_s15_1", got15[1], 32766);
        end

        // ---------------- bypass and mode switch ----------------
        got0.delete(); got15.delete();
        mode = 1'b1;
        drive(1, 5, 7);
        drive(0, 0, 0);
        repeat (3) @(posedge clk);
        #1 mode = 1'b0;
        drive(1, 0, 3);
        drive(0, 0, 0);
        drain();
        chk("bypass_n", got0.size(), 2);
        if (got0.size() == 2) begin
            chk("bypass_0", got0[0], 5);
            chk("bypass_s15_0", got15[0], 5);
            chk("modesw_1", got0[1], 15);
        end

        // ---------------- randomized bursts ----------------
        for (int b = 0; b < 8; b++) begin
            mode   = ($urandom_range(2) == 0);
            rd_pct = (b % 3 == 0) ? 30 : ((b % 3 == 1) ? 70 : 100);
            for (int n = 0; n < 40; n++)
                drive($urandom_range(9) < 7, rnd_s(), rnd_s());
            drive(0, 0, 0);
            drain();
        end
        mode = 1'b0;
        chk("count_vs_model", sample_count0, acc_cnt);
        chk("count_s15_vs_model", sample_count15, acc_cnt);

        // ---------------- backpressure and overflow ----------------
        clear_pulse();
        #1;
        chk("clear_count", sample_count0, 0);
        chk("clear_overflow", overflow0, 0);
        got0.delete(); got15.delete();
        for (int n = 0; n < 40; n++) drive(1, rnd_s(), rnd_s());
        drive(0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_retained", exp0.size(), 35);
        chk("bp_iq_full", iq_full0, 1);
        chk("bp_overflow", overflow0, 1);
        chk("bp_out_nonempty", data_out_empty0, 0);
        // Dropped write and clear on the same edge: clear wins.
        iq_wr_en = 1'b1;
        clear_status = 1'b1;
        @(posedge clk);
        #1;
        iq_wr_en = 1'b0;
        clear_status = 1'b0;
        #1;
        chk("clr_beats_ovf", overflow0, 0);
        chk("clr_count_stalled", sample_count0, 0);
        chk("bp_still_retained", exp0.size(), 35);
        drain();
        chk("bp_drained_n", got0.size(), 35);
        chk("bp_count_after", sample_count0, 19);

        // ---------------- reset mid-stream ----------------
        for (int n = 0; n < 10; n++)
            drive(1, rnd_s(), int'($urandom_range(1000)) + 1);
        @(posedge clk);
        #1 iq_wr_en = 1'b0;
        chk("pre_rst_nonempty", data_out_empty0, 0);
        chk("pre_rst_count_nz", (sample_count0 != 0), 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_empty", data_out_empty0, 1);
        chk("mid_rst_full", iq_full0, 0);
        chk("mid_rst_data", data_out0, 0);
        chk("mid_rst_count", sample_count0, 0);
        chk("mid_rst_overflow", overflow0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        got0.delete(); got15.delete();
        drive(1, 100, 0);
        drive(1, 0, 100);
        drive(0, 0, 0);
        drain();
        chk("post_rst_n", got0.size(), 2);
        if (got0.size() == 2) begin
            chk("post_rst_0", got0[0], 0);
            chk("post_rst_1", got0[1], 10000);
        end
        chk("post_rst_count", sample_count0, 2);

        // ---------------- clear coincident with output write ----------------
        got0.delete(); got15.delete();
        drive(1, 9, 4);            // edge N
        drive(0, 0, 0);
        repeat (3) @(posedge clk); // edge N+3
        #1 clear_status = 1'b1;
        @(posedge clk);            // edge N+4: output write and clear
        #1 clear_status = 1'b0;
        chk("clr_same_edge_count", sample_count0, 0);
        chk("clr_same_edge_written", data_out_empty0, 0);
        drain();
        chk("clr_same_edge_n", got0.size(), 1);
        chk("clr_count_hold", sample_count0, 0);
        drive(1, 1, 1);
        drive(0, 0, 0);
        drain();
        chk("count_after_clr", sample_count0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
